// File: rtl/cbc_byte_packer_pkg.sv
// Shared constants for the CBC byte packer: block/byte widths, FSM state encoding
// and the full PKCS#7 pad block appended to block-aligned messages.
package cbc_byte_packer_pkg;

    localparam int BLOCK_W = 64;
    localparam int BYTE_W  = 8;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_e;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    localparam logic [0:BLOCK_W-1] PAD_BLOCK = 64'h0808_0808_0808_0808;

endpackage

// File: rtl/cbc_byte_packer.sv
// Packs a byte stream into 64-bit big-endian blocks for the CBC-TDES core.
// Define CBC_PKCS7_PAD_EN for PKCS#7 padding; otherwise short final blocks are zero-filled.
module cbc_byte_packer
    import cbc_byte_packer_pkg::*;
(
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [7:0]        s_data_i,
    input  logic              s_valid_i,
    input  logic              s_last_i,
    input  logic              mode_i,
    output logic              s_ready_o,
    output logic [0:BLOCK_W-1] data_o,
    output logic              valid_o,
    output logic              start_o,
    output logic              last_o,
    output logic              mode_o,
    input  logic              ready_i
);

    state_e               state_q, state_d;
    logic [2:0]           cnt_q, cnt_d;
    logic [0:BLOCK_W-1]   data_q, data_d;
    logic                 start_q, start_d;
    logic                 last_q, last_d;
    logic                 mode_q, mode_d;
    logic                 pad_pending_q, pad_pending_d;
    logic                 first_q, first_d;

    // Writes byte b into lane k; on the final byte, lanes above k get the pad value.
    function automatic logic [0:BLOCK_W-1] lane_fill(
        input logic [0:BLOCK_W-1] blk,
        input logic [2:0]         k,
        input logic [7:0]         b,
        input logic               last
    );
        logic [0:BLOCK_W-1] r;
        logic [7:0]         pad;
        r = blk;
`ifdef CBC_PKCS7_PAD_EN
        pad = 8'd7 - {5'd0, k};
`else
        pad = 8'h00;
`endif
        for (int i = 0; i < BLOCK_W / BYTE_W; i++) begin
            if (i == int'(k)) begin
                r[BYTE_W*i +: BYTE_W] = b;
            end else if (last && (i > int'(k))) begin
                r[BYTE_W*i +: BYTE_W] = pad;
            end
        end
        return r;
    endfunction

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q       <= FILL;
            cnt_q         <= 3'd0;
            data_q        <= '0;
            start_q       <= 1'b0;
            last_q        <= 1'b0;
            mode_q        <= MODE_ENC;
            pad_pending_q <= 1'b0;
            first_q       <= 1'b1;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            data_q        <= data_d;
            start_q       <= start_d;
            last_q        <= last_d;
            mode_q        <= mode_d;
            pad_pending_q <= pad_pending_d;
            first_q       <= first_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        data_d        = data_q;
        start_d       = start_q;
        last_d        = last_q;
        mode_d        = mode_q;
        pad_pending_d = pad_pending_q;
        first_d       = first_q;

        if (state_q == FILL) begin
            if (s_valid_i) begin
                data_d  = lane_fill(data_q, cnt_q, s_data_i, s_last_i);
                cnt_d   = cnt_q + 3'd1;
                last_d  = s_last_i;
                first_d = s_last_i;
                if (cnt_q == 3'd0) begin
                    start_d = first_q;
                end
                if (first_q) begin
                    mode_d = mode_i;
                end
                if (s_last_i || (cnt_q == 3'd7)) begin
                    state_d = HOLD;
                end
`ifdef CBC_PKCS7_PAD_EN
                // Aligned end of message: this block is not last, a full pad block follows.
                if (s_last_i && (cnt_q == 3'd7)) begin
                    last_d        = 1'b0;
                    pad_pending_d = 1'b1;
                end
`endif
            end
        end else begin
            if (ready_i) begin
                if (pad_pending_q) begin
                    data_d        = PAD_BLOCK;
                    last_d        = 1'b1;
                    start_d       = 1'b0;
                    pad_pending_d = 1'b0;
                end else begin
                    state_d = FILL;
                    cnt_d   = 3'd0;
                end
            end
        end
    end

    assign s_ready_o = (state_q == FILL);
    assign valid_o   = (state_q == HOLD);
    assign data_o    = data_q;
    assign start_o   = start_q;
    assign last_o    = last_q;
    assign mode_o    = mode_q;

endmodule

// File: tb/tb_cbc_byte_packer.sv
// Randomized and directed bench for cbc_byte_packer against a message-level padding model.
// Follows CBC_PKCS7_PAD_EN the same way as the design build.
module tb_cbc_byte_packer;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b0;
    logic [7:0]  s_data_i = 8'h00;
    logic        s_valid_i = 1'b0;
    logic        s_last_i = 1'b0;
    logic        mode_i = 1'b0;
    logic        s_ready_o;
    logic [0:63] data_o;
    logic        valid_o;
    logic        start_o;
    logic        last_o;
    logic        mode_o;
    logic        ready_i = 1'b0;

    cbc_byte_packer dut (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .s_data_i  (s_data_i),
        .s_valid_i (s_valid_i),
        .s_last_i  (s_last_i),
        .mode_i    (mode_i),
        .s_ready_o (s_ready_o),
        .data_o    (data_o),
        .valid_o   (valid_o),
        .start_o   (start_o),
        .last_o    (last_o),
        .mode_o    (mode_o),
        .ready_i   (ready_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [7:0] d;
        bit         last;
        bit         mode;
        bit         first;
        int         pos;
    } in_t;

    typedef struct {
        logic [63:0] data;
        bit          start;
        bit          last;
        bit          mode;
    } blk_t;

    typedef logic [7:0] bq_t[$];

    in_t  in_q[$];
    blk_t exp_q[$];

    int tests = 0;
    int fails = 0;

    bit          model_mode = 1'b0;
    bit          expect_valid = 1'b0;
    bit          hold_prev = 1'b0;
    logic [63:0] prev_data;
    bit          prev_start, prev_last, prev_mode;
    int          stall_n = 0;
    bit          rand_ready = 1'b0;
    bit          rand_gap = 1'b0;
    int          blk_no = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: pad the whole message, then cut it into 8-byte big-endian blocks.
    task automatic add_msg(input bq_t m, input bit md);
        bq_t         pb;
        int          len;
        int          padn;
        int          nblk;
        blk_t        b;
        len = m.size();
        for (int i = 0; i < len; i++) begin
            in_q.push_back('{d: m[i], last: (i == len - 1), mode: md, first: (i == 0), pos: i});
        end
        pb = m;
`ifdef CBC_PKCS7_PAD_EN
        padn = 8 - (len % 8);
        for (int i = 0; i < padn; i++) pb.push_back(8'(padn));
`else
        padn = (len % 8 == 0) ? 0 : 8 - (len % 8);
        for (int i = 0; i < padn; i++) pb.push_back(8'h00);
`endif
        nblk = pb.size() / 8;
        for (int bi = 0; bi < nblk; bi++) begin
            b.data = '0;
            for (int j = 0; j < 8; j++) b.data = (b.data << 8) | 64'(pb[8*bi + j]);
            b.start = (bi == 0);
            b.last  = (bi == nblk - 1);
            b.mode  = md;
            exp_q.push_back(b);
        end
    endtask

    task automatic run(input int budget);
        int          cyc;
        logic [63:0] obs;
        blk_t        e;
        in_t         it;
        cyc = 0;
        while ((in_q.size() > 0 || exp_q.size() > 0) && cyc < budget) begin
            @(negedge clk_i);
            cyc++;
            obs = data_o;
            check("ready_vs_valid", 64'(s_ready_o), 64'(!valid_o));
            if (expect_valid) check("block_latency", 64'(valid_o), 64'd1);
            expect_valid = 1'b0;
            if (hold_prev) begin
                check("stall_valid", 64'(valid_o), 64'd1);
                check("stall_data", obs, prev_data);
                check("stall_flags", {61'd0, start_o, last_o, mode_o},
                      {61'd0, prev_start, prev_last, prev_mode});
            end
            if (!valid_o) check("mode_fill", 64'(mode_o), 64'(model_mode));

            if (valid_o) begin
                if (stall_n > 0) begin
                    ready_i = 1'b0;
                    stall_n--;
                end else begin
                    ready_i = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
                end
            end else begin
                ready_i = 1'($urandom_range(0, 1));
            end

            if (valid_o && ready_i) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_block", 64'(valid_o), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("blk_data", obs, e.data);
                    check("blk_start", 64'(start_o), 64'(e.start));
                    check("blk_last", 64'(last_o), 64'(e.last));
                    check("blk_mode", 64'(mode_o), 64'(e.mode));
                    $display("[TB] block %0d data=%h start=%0b last=%0b mode=%0b", blk_no, obs,
                             start_o, last_o, mode_o);
                    blk_no++;
                end
            end
            hold_prev  = valid_o && !ready_i;
            prev_data  = obs;
            prev_start = start_o;
            prev_last  = last_o;
            prev_mode  = mode_o;

            if (in_q.size() > 0 && (!rand_gap || $urandom_range(0, 3) != 0)) begin
                s_valid_i = 1'b1;
                s_data_i  = in_q[0].d;
                s_last_i  = in_q[0].last;
                mode_i    = in_q[0].mode;
            end else begin
                s_valid_i = 1'b0;
                s_data_i  = 8'($urandom);
                s_last_i  = 1'($urandom);
                mode_i    = 1'($urandom);
            end
            if (s_valid_i && s_ready_o) begin
                it = in_q.pop_front();
                if (it.first) model_mode = it.mode;
                if (it.last || (it.pos % 8 == 7)) expect_valid = 1'b1;
            end
        end
        if (cyc >= budget) check("timeout", 64'd0, 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s_ready"}, 64'(s_ready_o), 64'd1);
        check({tag, "_valid"}, 64'(valid_o), 64'd0);
        check({tag, "_data"}, 64'(data_o), 64'd0);
        check({tag, "_flags"}, {61'd0, start_o, last_o, mode_o}, 64'd0);
    endtask

    initial begin
        bq_t msg;

        // Power-on reset
        #12;
        check_reset_outputs("reset");
        @(negedge clk_i);
        reset_i = 1'b1;

        // Short message, ready always high
        msg.delete();
        for (int i = 0; i < 3; i++) msg.push_back(8'(i + 1));
        add_msg(msg, 1'b0);
        run(200);

        // Aligned 8-byte message
        msg.delete();
        for (int i = 0; i < 8; i++) msg.push_back(8'(i));
        add_msg(msg, 1'b0);
        run(200);

        // 16-byte message with the first block held off for 5 cycles
        msg.delete();
        for (int i = 0; i < 16; i++) msg.push_back(8'(8'h10 + i));
        add_msg(msg, 1'b0);
        stall_n = 5;
        run(300);

        // Back-to-back messages with different modes
        msg.delete();
        for (int i = 0; i < 5; i++) msg.push_back(8'(8'h20 + i));
        add_msg(msg, 1'b1);
        msg.delete();
        for (int i = 0; i < 11; i++) msg.push_back(8'(8'h30 + i));
        add_msg(msg, 1'b0);
        run(400);

        // Reset in the middle of a message
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            ready_i   = 1'b0;
            s_valid_i = 1'b1;
            s_data_i  = 8'(8'h50 + i);
            s_last_i  = 1'b0;
            mode_i    = 1'b1;
        end
        @(negedge clk_i);
        s_valid_i = 1'b0;
        reset_i   = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(negedge clk_i);
        reset_i      = 1'b1;
        model_mode   = 1'b0;
        hold_prev    = 1'b0;
        expect_valid = 1'b0;
        msg.delete();
        msg.push_back(8'hAA);
        msg.push_back(8'hBB);
        add_msg(msg, 1'b0);
        run(200);

        // Random messages with random byte gaps and downstream back-pressure
        rand_ready = 1'b1;
        rand_gap   = 1'b1;
        for (int m = 0; m < 25; m++) begin
            msg.delete();
            for (int i = 0; i < $urandom_range(1, 20); i++) msg.push_back(8'($urandom));
            add_msg(msg, 1'($urandom));
            if (m % 3 == 2) run(3000);
        end
        run(5000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
